ysyx_040750_rr_arbiter: RTL and testbench
=========================================

YSYX_040750_RR_ARBITER -- requirements
Module: ysyx_040750_rr_arbiter

Interface
REQ-001 Parameter N, default 64, request payload bitwidth.
REQ-002 Parameter M, default 4, number of requesters; M >= 2.
REQ-003 I_clk  input  1  single clock; all state updates on rising edge.
REQ-004 I_rst_n  input  1  asynchronous, active-low reset.
REQ-005 I_req_valid  input  M  bit i = requester i has a pending request.
REQ-006 I_req_data  input  N*M  requester i payload at bits [i*N +: N].
REQ-007 O_req_ready  output  M  one-hot accept pulse; payload i captured this cycle.
REQ-008 O_mem_valid  output  1  downstream request valid.
REQ-009 I_mem_ready  input  1  downstream accepts request.
REQ-010 O_mem_data  output  N  captured payload of granted requester.
REQ-011 I_resp_valid  input  1  downstream response for the outstanding request.
REQ-012 O_resp_valid  output  M  one-hot routing of I_resp_valid to granted requester.
REQ-013 O_grant  output  M  one-hot registered grant, all-zero when idle; legal direct select for a one-hot data mux.
REQ-014 O_busy  output  1  high whenever state is not IDLE.

Function
REQ-015 States SHALL be IDLE, REQ and WAIT, encoded in a registered state variable.
REQ-016 IDLE: if I_req_valid != 0, the block SHALL select index g = first set bit of I_req_valid, searching upward from (ptr+1) mod M with wrap-around.
REQ-017 In that selection cycle O_req_ready SHALL be one-hot at g (combinational from I_req_valid and ptr), payload g SHALL be captured into the data register, O_grant SHALL load one-hot g, and state SHALL move to REQ.
REQ-018 IDLE with I_req_valid == 0: O_req_ready = 0, no state change.
REQ-019 REQ: O_mem_valid = 1 and O_mem_data = captured payload, both stable until I_mem_ready = 1; on that cycle state SHALL move to WAIT.
REQ-020 WAIT: O_mem_valid = 0; when I_resp_valid = 1, O_resp_valid SHALL equal O_grant in the same cycle (combinational), ptr SHALL load g, O_grant SHALL clear, and state SHALL return to IDLE.
REQ-021 I_resp_valid outside WAIT SHALL be ignored; O_resp_valid = 0 outside WAIT.
REQ-022 Changes to I_req_valid/I_req_data after capture SHALL NOT affect O_mem_data or O_grant.
REQ-023 Exactly one transaction outstanding; minimum transaction period 3 cycles (IDLE, REQ, WAIT), next grant possible in the cycle after the response.
REQ-024 Fairness: a requester holding I_req_valid continuously SHALL be granted within M transactions.
REQ-025 O_req_ready, O_grant, O_resp_valid SHALL each be zero or one-hot in every cycle.

Reset
REQ-026 Asserting I_rst_n low at any time, including mid-transaction, SHALL immediately force state = IDLE, O_grant = 0, O_mem_valid = 0, O_busy = 0, O_req_ready = 0, O_resp_valid = 0, data register = 0.
REQ-027 ptr SHALL reset to M-1 so requester 0 has highest priority first after reset.
REQ-028 An aborted transaction SHALL NOT be resumed; a response arriving after reset release SHALL be ignored.

Structure
REQ-029 State encoding constants (IDLE, REQ, WAIT) SHALL live in the shared ysyx_040750 definitions package/include.
REQ-030 One sub-module ysyx_040750_rr_pick: combinational, inputs request vector and ptr, output one-hot selection; no other sub-modules.
REQ-031 Payload selection from I_req_data SHALL use AND-OR over the one-hot selection, no priority encoder on the data path.

Verification
REQ-032 Reset, then I_req_valid=4'b1111, I_mem_ready=1, I_resp_valid=1 in WAIT each time -> grants in order 0,1,2,3,0; O_req_ready one-hot each IDLE cycle.
REQ-033 Only requester 2 valid, payload 64'hDEAD_BEEF_0000_0002, I_mem_ready low 5 cycles -> O_mem_valid high 5+1 cycles, O_mem_data constant, O_grant=4'b0100 throughout.
REQ-034 After grant to 1, change I_req_data[1] to 64'h0 -> O_mem_data keeps captured value.
REQ-035 I_resp_valid pulsed during REQ -> ignored, O_resp_valid=0, state stays REQ; later pulse in WAIT -> O_resp_valid=4'b0010 one cycle.
REQ-036 Drop I_rst_n in WAIT with grant 3 -> same instant O_grant=0, O_busy=0; after release with I_req_valid=4'b1001 -> first grant to 0.
REQ-037 Random valid/ready/response stress 10k cycles -> one-hot invariants of REQ-025 and fairness bound of REQ-024 hold.

Source files
------------

// File: rtl/ysyx_040750_pkg.sv
// Shared definitions for the ysyx_040750 round-robin arbiter:
// controller state encoding and pointer-width helper.
package ysyx_040750_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Pointer width for an M-requester arbiter (at least one bit).
  function automatic int ptr_width(input int m);
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/ysyx_040750_rr_pick.sv
// Combinational round-robin picker: one-hot of the first set request bit,
// searching upward from (ptr+1) mod M with wrap-around.
module ysyx_040750_rr_pick
  import ysyx_040750_pkg::*;
#(
  parameter int M  = 4,
  parameter int PW = ptr_width(M)
) (
  input  logic [M-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [M-1:0]  sel
);

  always_comb begin
    int            pos;
    logic [PW-1:0] idx;
    logic          found;
    sel   = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = 1; k <= M; k++) begin
      pos = (int'(ptr) + k) % M;
      idx = pos[PW-1:0];
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_040750_rr_arbiter.sv
// Round-robin arbiter: one outstanding downstream transaction at a time,
// IDLE -> REQ (until mem_ready) -> WAIT (until response) -> IDLE.
module ysyx_040750_rr_arbiter
  import ysyx_040750_pkg::*;
#(
  parameter int N = 64,
  parameter int M = 4
) (
  input  logic           I_clk,
  input  logic           I_rst_n,
  input  logic [M-1:0]   I_req_valid,
  input  logic [N*M-1:0] I_req_data,
  output logic [M-1:0]   O_req_ready,
  output logic           O_mem_valid,
  input  logic           I_mem_ready,
  output logic [N-1:0]   O_mem_data,
  input  logic           I_resp_valid,
  output logic [M-1:0]   O_resp_valid,
  output logic [M-1:0]   O_grant,
  output logic           O_busy
);

  localparam int PW = ptr_width(M);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic [M-1:0]  grant;
  logic [N-1:0]  data;

  logic [M-1:0]  sel;
  logic [PW-1:0] sel_idx;
  logic [N-1:0]  sel_data;
  logic [N-1:0]  masked [M];

  ysyx_040750_rr_pick #(.M(M), .PW(PW)) u_pick (
    .req (I_req_valid),
    .ptr (ptr),
    .sel (sel)
  );

  // Payload mux is a plain AND-OR over the one-hot selection.
  for (genvar gi = 0; gi < M; gi++) begin : g_mask
    assign masked[gi] = {N{sel[gi]}} & I_req_data[gi*N +: N];
  end

  always_comb begin
    sel_data = '0;
    sel_idx  = '0;
    for (int i = 0; i < M; i++) begin
      sel_data = sel_data | masked[i];
      if (sel[i]) sel_idx = sel_idx | PW'(i);
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state     <= ST_IDLE;
      ptr       <= PW'(M - 1);
      grant_idx <= '0;
      grant     <= '0;
      data      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|sel) begin
            data      <= sel_data;
            grant     <= sel;
            grant_idx <= sel_idx;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (I_mem_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (I_resp_valid) begin
            ptr   <= grant_idx;
            grant <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Reset gates the accept pulse so nothing is acknowledged while held in reset.
  assign O_req_ready  = (state == ST_IDLE && I_rst_n) ? sel : '0;
  assign O_mem_valid  = (state == ST_REQ);
  assign O_mem_data   = data;
  assign O_resp_valid = (state == ST_WAIT && I_resp_valid) ? grant : '0;
  assign O_grant      = grant;
  assign O_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_ysyx_040750_rr_arbiter.sv
// Self-checking bench for ysyx_040750_rr_arbiter: table-driven grant order,
// hand-written corner sequences and a randomized run against a reference model.
module tb_ysyx_040750_rr_arbiter;

  localparam int N = 64;
  localparam int M = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [M-1:0]   req_valid = '0;
  logic [N*M-1:0] req_data = '0;
  logic [M-1:0]   req_ready;
  logic           mem_valid;
  logic           mem_ready = 1'b0;
  logic [N-1:0]   mem_data;
  logic           resp_valid = 1'b0;
  logic [M-1:0]   resp_valid_o;
  logic [M-1:0]   grant;
  logic           busy;

  ysyx_040750_rr_arbiter #(.N(N), .M(M)) dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_req_valid  (req_valid),
    .I_req_data   (req_data),
    .O_req_ready  (req_ready),
    .O_mem_valid  (mem_valid),
    .I_mem_ready  (mem_ready),
    .O_mem_data   (mem_data),
    .I_resp_valid (resp_valid),
    .O_resp_valid (resp_valid_o),
    .O_grant      (grant),
    .O_busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: transaction phase (0 idle, 1 presenting, 2 awaiting
  // response), index of the granted requester, last winner, captured payload.
  int           m_phase;
  int           m_g;
  int           m_last;
  logic [N-1:0] m_data;
  int           starve [M];

  function automatic int rr_choose(input logic [M-1:0] v, input int last);
    for (int j = 1; j <= M; j++) begin
      if (v[(last + j) % M]) return (last + j) % M;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_g     = -1;
    m_last  = M - 1;
    m_data  = '0;
    for (int i = 0; i < M; i++) starve[i] = 0;
  endtask

  // Compare every output with the model for the current cycle, then advance
  // the model across the coming rising edge.
  task automatic check_cycle();
    int           winner;
    logic [M-1:0] e_ready, e_grant, e_resp;
    winner  = (m_phase == 0) ? rr_choose(req_valid, m_last) : -1;
    e_ready = (winner >= 0) ? M'(1 << winner) : '0;
    e_grant = (m_g >= 0) ? M'(1 << m_g) : '0;
    e_resp  = (m_phase == 2 && resp_valid) ? e_grant : '0;
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("grant", 64'(grant), 64'(e_grant));
    chk("mem_valid", 64'(mem_valid), 64'(m_phase == 1));
    chk("mem_data", mem_data, m_data);
    chk("resp_valid", 64'(resp_valid_o), 64'(e_resp));
    chk("busy", 64'(busy), 64'(m_phase != 0));
    chk("onehot", 64'($onehot0(req_ready) && $onehot0(grant) && $onehot0(resp_valid_o)), 64'(1));
    for (int i = 0; i < M; i++) begin
      if (!req_valid[i]) starve[i] = 0;
      else if (winner >= 0 && i != winner) begin
        starve[i]++;
        chk("fairness", 64'(starve[i] <= M - 1), 64'(1));
      end
    end
    if (winner >= 0) starve[winner] = 0;
    case (m_phase)
      0: if (winner >= 0) begin
        m_g = winner; m_data = req_data[winner*N +: N]; m_phase = 1;
      end
      1: if (mem_ready) m_phase = 2;
      default: if (resp_valid) begin
        m_last = m_g; m_g = -1; m_phase = 0;
      end
    endcase
  endtask

  // Inputs are set at a falling edge; outputs are checked 1 time unit later.
  task automatic cyc();
    #1;
    check_cycle();
    @(negedge clk);
  endtask

  typedef struct {
    logic [M-1:0] req_valid;
    logic         mem_ready;
    logic         resp_valid;
    logic [M-1:0] exp_ready;
    logic [M-1:0] exp_grant;
    logic         exp_mem_valid;
    logic [M-1:0] exp_resp;
  } vec_t;

  vec_t vecs [15];
  int   order [5];
  int   mv_cnt;
  logic [N-1:0] held;

  initial begin
    // Full-request round robin: each transaction is IDLE, REQ, WAIT.
    order = '{0, 1, 2, 3, 0};
    for (int t = 0; t < 5; t++) begin
      vecs[3*t]   = '{4'b1111, 1'b1, 1'b0, M'(1 << order[t]), 4'b0000, 1'b0, 4'b0000};
      vecs[3*t+1] = '{4'b1111, 1'b1, 1'b0, 4'b0000, M'(1 << order[t]), 1'b1, 4'b0000};
      vecs[3*t+2] = '{4'b1111, 1'b1, 1'b1, 4'b0000, M'(1 << order[t]), 1'b0, M'(1 << order[t])};
    end

    // Reset with requests already pending: nothing may be accepted.
    req_valid = 4'b1111;
    for (int i = 0; i < M; i++) req_data[i*N +: N] = {32'hA5A5_0000, 32'(i)};
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_mem_valid", 64'(mem_valid), 64'(0));
    chk("rst_mem_data", mem_data, 64'(0));
    chk("rst_resp", 64'(resp_valid_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int v = 0; v < 15; v++) begin
      req_valid  = vecs[v].req_valid;
      mem_ready  = vecs[v].mem_ready;
      resp_valid = vecs[v].resp_valid;
      #1;
      chk($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(vecs[v].exp_ready));
      chk($sformatf("vec%0d_grant", v), 64'(grant), 64'(vecs[v].exp_grant));
      chk($sformatf("vec%0d_mem_valid", v), 64'(mem_valid), 64'(vecs[v].exp_mem_valid));
      chk($sformatf("vec%0d_resp", v), 64'(resp_valid_o), 64'(vecs[v].exp_resp));
      #1;
      check_cycle();
      @(negedge clk);
    end

    // Stalled downstream: requester 2 held for 5 not-ready cycles.
    req_valid = 4'b0100; resp_valid = 1'b0; mem_ready = 1'b0;
    req_data[2*N +: N] = 64'hDEAD_BEEF_0000_0002;
    cyc();
    mv_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      mem_ready = (c == 5);
      #1;
      if (mem_valid) mv_cnt++;
      chk("stall_data", mem_data, 64'hDEAD_BEEF_0000_0002);
      chk("stall_grant", 64'(grant), 64'(4'b0100));
      #1;
      check_cycle();
      @(negedge clk);
    end
    chk("stall_mem_valid_cycles", 64'(mv_cnt), 64'(6));
    mem_ready = 1'b0; resp_valid = 1'b1; req_valid = 4'b0000;
    cyc();

    // Capture isolation and response ignored outside WAIT.
    resp_valid = 1'b0;
    req_valid = 4'b0010;
    req_data[1*N +: N] = 64'h1111_2222_3333_4444;
    cyc();
    held = req_data[1*N +: N];
    req_data[1*N +: N] = 64'h0;
    req_valid = 4'b0000;
    resp_valid = 1'b1;
    #1;
    chk("early_resp_ignored", 64'(resp_valid_o), 64'(0));
    chk("held_data", mem_data, held);
    #1; check_cycle(); @(negedge clk);
    resp_valid = 1'b0;
    #1;
    chk("still_req", 64'(mem_valid), 64'(1));
    #1; check_cycle(); @(negedge clk);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0; resp_valid = 1'b1;
    #1;
    chk("wait_resp", 64'(resp_valid_o), 64'(4'b0010));
    #1; check_cycle(); @(negedge clk);
    #1;
    chk("resp_one_cycle", 64'(resp_valid_o), 64'(0));
    #1; check_cycle(); @(negedge clk);

    // Reset in WAIT with grant 3, then restart with requesters 0 and 3.
    resp_valid = 1'b0; req_valid = 4'b1000; mem_ready = 1'b1;
    cyc();
    req_valid = 4'b0000;
    cyc();
    #1;
    chk("pre_rst_grant", 64'(grant), 64'(4'b1000));
    chk("pre_rst_busy", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_grant", 64'(grant), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_mem_data", mem_data, 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b1001; resp_valid = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'(4'b0001));
    #1; check_cycle(); @(negedge clk);
    resp_valid = 1'b0;

    // Randomized stress with persistent requests.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < M; i++) begin
        if (req_valid[i]) req_valid[i] = ($urandom_range(7) != 0);
        else req_valid[i] = ($urandom_range(3) == 0);
        req_data[i*N +: N] = {$urandom, $urandom};
      end
      mem_ready  = $urandom_range(1);
      resp_valid = $urandom_range(1);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
